// File: rtl/alu_regfile.sv
// alu_regfile: a small register file (2**ADDR_W x DATA_W) with two
// combinational read ports and one synchronous write port, next to an
// independent combinational ALU. The ALU result only returns to the
// register file through data_in/write_en, so the two never share a path.
//
// Optional feature: define WRITE_BYPASS_EN so that a read port whose address
// matches an active write shows data_in in the same cycle. Without it, a read
// returns the stored value until the write edge.
module alu_regfile #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   read_addr1,
    input  logic [ADDR_W-1:0]   read_addr2,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                write_en,
    output logic [DATA_W-1:0]   read_out1,
    output logic [DATA_W-1:0]   read_out2,
    input  logic [2*DATA_W+2:0] alu_instr,
    output logic [DATA_W-1:0]   alu_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    // ALU opcodes
    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_EQ   = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Storage is held in flops rather than block RAM: reads are zero-latency
    // and reset must clear every entry in one edge.
    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  wr_sel;

    // One-hot write decode, one bit per register.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = write_en && (write_addr == ADDR_W'(gi));
        end
    endgenerate

    // Register update: reset clears everything and wins over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= data_in;
                end
            end
        end
    end

    // Read ports, optionally forwarding the in-flight write.
`ifdef WRITE_BYPASS_EN
    logic wr_active;
    assign wr_active = write_en && !rst;

    always_comb begin
        read_out1 = regs_reg[read_addr1];
        read_out2 = regs_reg[read_addr2];
        if (wr_active && (read_addr1 == write_addr)) begin
            read_out1 = data_in;
        end
        if (wr_active && (read_addr2 == write_addr)) begin
            read_out2 = data_in;
        end
    end
`else
    always_comb begin
        read_out1 = regs_reg[read_addr1];
        read_out2 = regs_reg[read_addr2];
    end
`endif

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [2:0]        opcode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        shift_amt;

    assign opcode    = alu_instr[2*DATA_W+2:2*DATA_W];
    assign op_a      = alu_instr[2*DATA_W-1:DATA_W];
    assign op_b      = alu_instr[DATA_W-1:0];
    assign shift_amt = op_b[3:0];

    // Pure combinational result; sums and differences wrap at DATA_W bits.
    // The shift is evaluated at DATA_W width, so any amount >= DATA_W
    // naturally pushes every bit out and yields zero.
    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ZERO: alu_out = '0;
            OP_ADD:  alu_out = op_a + op_b;
            OP_SUB:  alu_out = op_a - op_b;
            OP_AND:  alu_out = op_a & op_b;
            OP_OR:   alu_out = op_a | op_b;
            OP_XOR:  alu_out = op_a ^ op_b;
            OP_EQ:   alu_out = (op_a == op_b) ? DATA_W'(1) : '0;
            OP_SHL:  alu_out = op_a << shift_amt;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Testbench for alu_regfile: directed steps followed by a randomized phase,
// all checked against a behavioural model (integer array + arithmetic ALU).
module tb_alu_regfile;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int MODV   = 4096;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   read_addr1;
    logic [ADDR_W-1:0]   read_addr2;
    logic [ADDR_W-1:0]   write_addr;
    logic [DATA_W-1:0]   data_in;
    logic                write_en;
    logic [DATA_W-1:0]   read_out1;
    logic [DATA_W-1:0]   read_out2;
    logic [2*DATA_W+2:0] alu_instr;
    logic [DATA_W-1:0]   alu_out;

    int total = 0;
    int bad   = 0;
    int model [DEPTH];

    alu_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_addr1(read_addr1),
        .read_addr2(read_addr2),
        .write_addr(write_addr),
        .data_in   (data_in),
        .write_en  (write_en),
        .read_out1 (read_out1),
        .read_out2 (read_out2),
        .alu_instr (alu_instr),
        .alu_out   (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU written from the opcode table with plain integer maths.
    function automatic int alu_ref(input int op, input int a, input int b);
        int s;
        case (op)
            1: return (a + b) % MODV;
            2: return (a - b + MODV) % MODV;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return (a == b) ? 1 : 0;
            7: begin
                s = b % 16;
                if (s >= DATA_W) return 0;
                return (a * (1 << s)) % MODV;
            end
            default: return 0;
        endcase
    endfunction

    // Expected read value for an address given the current (pre-edge) inputs.
    function automatic int read_ref(input int addr);
`ifdef WRITE_BYPASS_EN
        if (write_en && !rst && addr == int'(write_addr)) return int'(data_in);
`endif
        return model[addr];
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input int exp);
        logic [DATA_W-1:0] e;
        e = DATA_W'(exp);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, e);
    endtask

    function automatic logic [2*DATA_W+2:0] mk_instr(input int op, input int a, input int b);
        return {3'(op), DATA_W'(a), DATA_W'(b)};
    endfunction

    // Advance one rising edge, updating the model from the inputs at that edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 0;
        end else if (write_en) begin
            model[write_addr] = int'(data_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int addr, input int val);
        write_en   = 1'b1;
        write_addr = ADDR_W'(addr);
        data_in    = DATA_W'(val);
        tick();
        write_en   = 1'b0;
    endtask

    task automatic check_reads(input string tag, input int a1, input int a2);
        read_addr1 = ADDR_W'(a1);
        read_addr2 = ADDR_W'(a2);
        #1;
        check({tag, "_r1"}, read_out1, read_ref(a1));
        check({tag, "_r2"}, read_out2, read_ref(a2));
    endtask

    initial begin
        int ops [6];
        int res;
        int wa, a, b, op;
        ops = '{1, 2, 3, 4, 7, 0};

        rst = 1'b0; write_en = 1'b0; write_addr = '0; data_in = '0;
        read_addr1 = '0; read_addr2 = '0; alu_instr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;

        // Reset: ALU must keep working while rst is high.
        rst = 1'b1;
        alu_instr = mk_instr(1, 'h0F7C, 'h002);
        #1;
        check("alu_in_rst", alu_out, 'hF7E);
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i += 2) check_reads("reset", i, i + 1);

        // Basic writes including address 0 and duplicate values.
        write_reg(0, 'hF7C);
        write_reg(1, 'h002);
        write_reg(5, 'h440);
        write_reg(6, 'h440);
        check_reads("wr01", 0, 1);
        check_reads("wr56", 5, 6);
        check_reads("same", 5, 5);

        // ALU ops with A=0xF7C, B=0x002; write each result back and read it.
        for (int i = 0; i < 5; i++) begin
            alu_instr = mk_instr(ops[i], 'hF7C, 'h002);
            #1;
            res = alu_ref(ops[i], 'hF7C, 'h002);
            check($sformatf("alu_op%0d", ops[i]), alu_out, res);
            write_reg(2 + (i % 3), int'(alu_out));
            check_reads("alu_wb", 2 + (i % 3), 2 + (i % 3));
        end

        // Wrap-around and shift boundaries.
        alu_instr = mk_instr(1, 'hFFF, 'h001); #1; check("add_wrap", alu_out, 0);
        alu_instr = mk_instr(2, 'h000, 'h001); #1; check("sub_wrap", alu_out, 'hFFF);
        alu_instr = mk_instr(7, 'h001, 'h00B); #1; check("shl_11", alu_out, 'h800);
        alu_instr = mk_instr(7, 'hFFF, 'h00C); #1; check("shl_12", alu_out, 0);
        alu_instr = mk_instr(7, 'hFFF, 'h01F); #1; check("shl_15", alu_out, 0);

        // A == B cases.
        alu_instr = mk_instr(5, 'h440, 'h440); #1; check("xor_eq", alu_out, 0);
        alu_instr = mk_instr(6, 'h440, 'h440); #1; check("eq_true", alu_out, 1);
        write_reg(7, int'(alu_out));
        check_reads("r7", 7, 6);
        alu_instr = mk_instr(6, 'h440, 'h441); #1; check("eq_false", alu_out, 0);
        alu_instr = mk_instr(0, 'h440, 'h440); #1; check("op_zero", alu_out, 0);

        // Reset wins over a simultaneous write.
        write_reg(2, 'h5A5);
        rst = 1'b1;
        write_reg(2, 'h777);
        rst = 1'b0;
        check_reads("rst_wr", 2, 0);

        // Disabled write must leave everything unchanged.
        write_reg(4, 'h321);
        write_en = 1'b0; write_addr = 3'd4; data_in = 'hABC;
        tick();
        for (int i = 0; i < DEPTH; i += 2) check_reads("no_we", i, i + 1);

        // Same-cycle read/write of r3.
        write_reg(3, 'h0AA);
        write_en = 1'b1; write_addr = 3'd3; data_in = 'h123;
        check_reads("rw_before", 3, 4);
        tick();
        write_en = 1'b0;
        check_reads("rw_after", 3, 4);

        // Randomized phase.
        for (int n = 0; n < 300; n++) begin
            rst        = ($urandom_range(0, 19) == 0);
            write_en   = $urandom_range(0, 1) == 1;
            write_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            data_in    = DATA_W'($urandom);
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, MODV - 1);
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, MODV - 1);
            alu_instr = mk_instr(op, a, b);
            check_reads("rand", $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            check("rand_alu", alu_out, alu_ref(op, a, b));
            tick();
        end
        rst = 1'b0; write_en = 1'b0;
        for (int i = 0; i < DEPTH; i += 2) check_reads("final", i, i + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 Parameter DATA_W, default 12: register, operand and result width.
REQ-002 Parameter ADDR_W, default 3: register address width; depth is 2**ADDR_W (8 registers).
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 read_addr1  input  ADDR_W: read port 1 address.
REQ-006 read_addr2  input  ADDR_W: read port 2 address.
REQ-007 write_addr  input  ADDR_W: write port address.
REQ-008 data_in  input  DATA_W: write data.
REQ-009 write_en  input  1: write enable, active-high.
REQ-010 read_out1  output  DATA_W: contents of register read_addr1.
REQ-011 read_out2  output  DATA_W: contents of register read_addr2.
REQ-012 alu_instr  input  2*DATA_W+3 (27): [26:24] opcode, [23:12] operand A, [11:0] operand B.
REQ-013 alu_out  output  DATA_W: ALU result.

Function
REQ-014 Register file SHALL hold 2**ADDR_W registers of DATA_W bits, all writable, including address 0.
REQ-015 Write SHALL occur on rising clk edge when write_en=1 and rst=0: reg[write_addr] <= data_in; no other register changes.
REQ-016 Read ports SHALL be combinational (zero latency) and independent; both may address the same register.
REQ-017 Read of the register being written in the same cycle SHALL return the old value until the edge (no bypass unless REQ-026).
REQ-018 ALU SHALL be purely combinational; alu_out depends only on alu_instr, not on register contents or clk.
REQ-019 Opcodes (A, B unsigned; results truncated to DATA_W, carry/borrow discarded): 000 -> 0; 001 A+B; 010 A-B (mod 2**DATA_W); 011 A&B; 100 A|B; 101 A^B; 110 (A==B) ? 1 : 0; 111 A << B[3:0] (zero fill; shift >= DATA_W gives 0).
REQ-020 Overflow SHALL wrap silently: 0xFFF+0x001 -> 0x000; 0x000-0x001 -> 0xFFF.
REQ-021 ALU and register file SHALL share no internal path; the result is written back only through data_in/write_en.

Reset
REQ-022 When rst=1 at a rising clk edge, all registers SHALL clear to 0; rst has priority over a simultaneous write.
REQ-023 During and after reset, read_out1/read_out2 SHALL show 0 for every address until written; alu_out is unaffected by rst.
REQ-024 Reset asserted mid-sequence SHALL discard that cycle's write; writes resume on the first edge with rst=0.
REQ-025 No register SHALL change value other than through REQ-015 or REQ-022.

Configuration
REQ-026 Macro WRITE_BYPASS_EN: when defined, a read port whose address equals write_addr while write_en=1 and rst=0 SHALL output data_in combinationally. When undefined, REQ-017 applies.

Verification
REQ-027 rst=1 one edge, then read all 8 addresses -> every read_out = 0x000.
REQ-028 Write r0=0xF7C, r1=0x002, r5=0x440, r6=0x440 on successive edges; read (0,1) -> 0xF7C/0x002; read (5,6) -> 0x440/0x440.
REQ-029 alu_instr A=0xF7C, B=0x002 with opcodes 001..100 and 111 -> 0xF7E, 0xF7A, 0x000, 0xF7E, 0xDF0; write each to r2/r3/r4 and read back identical.
REQ-030 A=B=0x440: opcode 101 -> 0x000; opcode 110 -> 0x001; write to r7, read r7 -> matching value; opcode 000 -> 0x000.
REQ-031 write_en=1 and rst=1 on same edge to r2 -> r2 reads 0x000; write_en=0 with data_in=0xABC -> no register changes.
REQ-032 Same-cycle read/write of r3 with data_in=0x123 -> read_out shows old value before the edge and 0x123 after; with WRITE_BYPASS_EN defined, 0x123 immediately.
